uart_fpu_sequencer: RTL and testbench
=====================================

// Module: uart_fpu_sequencer
// PURPOSE
//  Controller between the UART receive path and the FP arithmetic unit. Takes the operand
//  pair delivered by the UART Rx block (o_data_a/o_data_b + o_done), launches one FPU operation,
//  and streams the 32-bit result back out through the UART Tx byte interface, MSB byte first.
//  Guards against a hung FPU with a watchdog, and flags operand pairs dropped while busy.
// PARAMETERS
//  SIZE_DATA    32       operand/result width; must be a multiple of SIZE_BYTE
//  SIZE_BYTE    8        UART Tx byte width
//  TIMEOUT_CYC  4096     max cycles in WAIT_FPU before abort; >=2
// PORTS
//  i_clk         in   1          system clock
//  i_rst_n       in   1          asynchronous active-low reset
//  i_rx_done     in   1          1-cycle pulse: i_data_a/i_data_b valid
//  i_data_a      in   SIZE_DATA  operand A from Rx block
//  i_data_b      in   SIZE_DATA  operand B from Rx block
//  o_fpu_start   out  1          1-cycle launch pulse to FPU
//  o_fpu_a       out  SIZE_DATA  latched operand A; stable from launch until return to IDLE
//  o_fpu_b       out  SIZE_DATA  latched operand B; same stability rule
//  i_fpu_done    in   1          1-cycle pulse: i_fpu_result valid
//  i_fpu_result  in   SIZE_DATA  FPU result
//  o_tx_start    out  1          1-cycle pulse: send o_tx_data
//  o_tx_data     out  SIZE_BYTE  byte to transmit; held until the next o_tx_start
//  i_tx_busy     in   1          Tx serializer busy; no o_tx_start while high
//  i_tx_done     in   1          1-cycle pulse: current byte fully sent
//  o_busy        out  1          high in every state except IDLE
//  o_sent        out  1          1-cycle pulse: last result byte acknowledged
//  o_drop        out  1          1-cycle pulse: i_rx_done seen outside IDLE, pair ignored
//  o_error       out  1          sticky: FPU watchdog expired; cleared only by reset
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, every output 0, counters/indices 0, result reg 0.
//  - States: IDLE, START, WAIT_FPU, SEND, WAIT_TX. NB = SIZE_DATA/SIZE_BYTE bytes.
//  - IDLE: i_rx_done at edge N -> o_fpu_a/b latch inputs at N; state START; o_busy=1 from N.
//  - START: o_fpu_start high for exactly one cycle (edge N+1 to N+2); wdog=0; go WAIT_FPU.
//  - WAIT_FPU: wdog increments each cycle. i_fpu_done -> latch i_fpu_result, idx=NB-1, go SEND.
//    Timeout when wdog reaches TIMEOUT_CYC-1 without done -> o_error=1, go IDLE, nothing sent.
//    i_fpu_done and timeout in same cycle -> done wins, no error.
//  - SEND: while i_tx_busy=1 wait. When i_tx_busy=0 -> o_tx_start pulse with
//    o_tx_data=result[idx*SIZE_BYTE +: SIZE_BYTE]; go WAIT_TX.
//  - WAIT_TX: i_tx_done -> if idx==0: o_sent pulse, go IDLE; else idx-=1, go SEND.
//  - Stray pulses ignored: i_fpu_done outside WAIT_FPU; i_tx_done outside WAIT_TX.
//  - i_rx_done in any state other than IDLE -> o_drop pulse next cycle; latched operands and
//    state unaffected. The same-cycle transition into IDLE counts as not IDLE (dropped).
//  - Back-to-back: an i_rx_done in the first IDLE cycle after o_sent is accepted.
//  - Asynchronous reset mid-operation: immediate return to IDLE with all reset values, including
//    o_error=0. A pending Tx byte is abandoned and no o_sent is issued.
// TESTING
//  1 a=0x3F800000 b=0x40000000 with rx_done; FPU model returns 0x40400000 after 5 cyc ->
//    one o_fpu_start one cycle after rx_done; tx bytes 0x40,0x40,0x00,0x00; one o_sent; o_busy->0.
//  2 TIMEOUT_CYC=16, FPU never answers -> o_error=1 exactly 16 cycles after WAIT_FPU entry;
//    no o_tx_start; IDLE; next pair still processed, o_error stays 1.
//  3 second rx_done during WAIT_FPU with a=0xDEADBEEF -> o_drop pulse; o_fpu_a keeps first value;
//    result of the first pair sent unchanged.
//  4 hold i_tx_busy=1 for 20 cyc on entry to SEND -> no o_tx_start until busy falls, then within
//    1 cycle; o_tx_data stable across the hold.
//  5 i_fpu_done on the same cycle wdog hits TIMEOUT_CYC-1 -> no error; all 4 bytes sent.
//  6 assert i_rst_n=0 after the 2nd byte is sent -> all outputs 0 at once; after release, no o_sent
//    and no o_tx_start until a new rx_done.

Source files
------------

// File: rtl/uart_fpu_sequencer.sv
// uart_fpu_sequencer
// Sequences one FPU operation per operand pair received over UART, then
// streams the result back out through the UART Tx byte interface, MSB byte
// first. A watchdog aborts a hung FPU (sticky o_error), and operand pairs
// that arrive while busy are dropped and reported on o_drop.

module uart_fpu_sequencer #(
    parameter int SIZE_DATA   = 32,
    parameter int SIZE_BYTE   = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    // operand pair from the Rx block
    input  logic                 i_rx_done,
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    // FPU handshake
    output logic                 o_fpu_start,
    output logic [SIZE_DATA-1:0] o_fpu_a,
    output logic [SIZE_DATA-1:0] o_fpu_b,
    input  logic                 i_fpu_done,
    input  logic [SIZE_DATA-1:0] i_fpu_result,
    // Tx byte interface
    output logic                 o_tx_start,
    output logic [SIZE_BYTE-1:0] o_tx_data,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done,
    // status
    output logic                 o_busy,
    output logic                 o_sent,
    output logic                 o_drop,
    output logic                 o_error
);

    localparam int NB    = SIZE_DATA / SIZE_BYTE;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int WD_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NB - 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_WAIT_FPU = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_WAIT_TX  = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [WD_W-1:0]      r_wdog;
    logic [IDX_W-1:0]     r_idx;
    logic [SIZE_DATA-1:0] r_result;
    logic [SIZE_DATA-1:0] r_fpu_a;
    logic [SIZE_DATA-1:0] r_fpu_b;
    logic                 r_fpu_start;
    logic                 r_tx_start;
    logic [SIZE_BYTE-1:0] r_tx_data;
    logic                 r_busy;
    logic                 r_sent;
    logic                 r_drop;
    logic                 r_error;

    logic                 w_accept;
    logic                 w_fpu_ok;
    logic                 w_timeout;
    logic                 w_tx_go;
    logic                 w_byte_ack;
    logic                 w_last_ack;
    logic [SIZE_BYTE-1:0] w_byte;

    // Event decode; done beats the watchdog when both land in one cycle.
    assign w_accept   = (r_state == S_IDLE) && i_rx_done;
    assign w_fpu_ok   = (r_state == S_WAIT_FPU) && i_fpu_done;
    assign w_timeout  = (r_state == S_WAIT_FPU) && !i_fpu_done && (r_wdog == WD_LAST);
    assign w_tx_go    = (r_state == S_SEND) && !i_tx_busy;
    assign w_byte_ack = (r_state == S_WAIT_TX) && i_tx_done;
    assign w_last_ack = w_byte_ack && (r_idx == '0);

    // Select the result byte addressed by r_idx (MSB byte sent first).
    always_comb begin
        w_byte = '0;
        for (int k = 0; k < NB; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_byte = r_result[k*SIZE_BYTE +: SIZE_BYTE];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_nxt = S_START;
            S_START:    w_state_nxt = S_WAIT_FPU;
            S_WAIT_FPU: begin
                if (w_fpu_ok)       w_state_nxt = S_SEND;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_SEND:     if (w_tx_go) w_state_nxt = S_WAIT_TX;
            S_WAIT_TX: begin
                if (w_last_ack)      w_state_nxt = S_IDLE;
                else if (w_byte_ack) w_state_nxt = S_SEND;
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // State register and registered busy flag (tracks next state so it is
    // high from the accepting edge and low from the edge that re-enters IDLE).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Operand latch: only an accepted pair updates the FPU operands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fpu_a <= '0;
            r_fpu_b <= '0;
        end else if (w_accept) begin
            r_fpu_a <= i_data_a;
            r_fpu_b <= i_data_b;
        end
    end

    // Launch pulse and watchdog; the watchdog is cleared on launch and
    // counts every cycle spent waiting on the FPU.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fpu_start <= 1'b0;
            r_wdog      <= '0;
        end else begin
            r_fpu_start <= (r_state == S_START);
            if (r_state == S_START) begin
                r_wdog <= '0;
            end else if ((r_state == S_WAIT_FPU) && !w_fpu_ok && !w_timeout) begin
                r_wdog <= r_wdog + WD_W'(1);
            end
        end
    end

    // Result capture and byte index walk-down.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result <= '0;
            r_idx    <= '0;
        end else if (w_fpu_ok) begin
            r_result <= i_fpu_result;
            r_idx    <= IDX_MSB;
        end else if (w_byte_ack && !w_last_ack) begin
            r_idx <= r_idx - IDX_W'(1);
        end
    end

    // Tx byte issue; o_tx_data holds until the next start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= w_tx_go;
            if (w_tx_go) begin
                r_tx_data <= w_byte;
            end
        end
    end

    // Status pulses and the sticky watchdog error. A pair arriving on the
    // cycle that returns to IDLE still sees a non-IDLE state and is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sent  <= 1'b0;
            r_drop  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_sent <= w_last_ack;
            r_drop <= i_rx_done && (r_state != S_IDLE);
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_fpu_start = r_fpu_start;
    assign o_fpu_a     = r_fpu_a;
    assign o_fpu_b     = r_fpu_b;
    assign o_tx_start  = r_tx_start;
    assign o_tx_data   = r_tx_data;
    assign o_busy      = r_busy;
    assign o_sent      = r_sent;
    assign o_drop      = r_drop;
    assign o_error     = r_error;

endmodule

// File: tb/tb_uart_fpu_sequencer.sv
// Bench for uart_fpu_sequencer: FPU and Tx responders run on the falling
// edge; the main thread applies a table of operand/result vectors and a few
// hand-written sequences (drop, Tx busy hold, watchdog, async reset).

module tb_uart_fpu_sequencer;

    localparam int TO     = 16;
    localparam int TX_LEN = 4;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [31:0]      res;
        int               lat;
        logic [3:0][7:0]  eb;   // eb[3] is the first byte expected on the wire
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_done = 1'b0;
    logic [31:0] da = '0, db = '0;
    logic        fpu_start, tx_start, busy, sent, drop, error;
    logic [31:0] fpu_a, fpu_b;
    logic [7:0]  tx_data;
    logic        fpu_done = 1'b0;
    logic [31:0] fpu_res = '0;
    logic        tx_busy_m = 1'b0, force_busy = 1'b0, tx_done = 1'b0;
    logic        tx_busy;

    assign tx_busy = tx_busy_m | force_busy;

    uart_fpu_sequencer #(.SIZE_DATA(32), .SIZE_BYTE(8), .TIMEOUT_CYC(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_done(rx_done), .i_data_a(da), .i_data_b(db),
        .o_fpu_start(fpu_start), .o_fpu_a(fpu_a), .o_fpu_b(fpu_b),
        .i_fpu_done(fpu_done), .i_fpu_result(fpu_res),
        .o_tx_start(tx_start), .o_tx_data(tx_data),
        .i_tx_busy(tx_busy), .i_tx_done(tx_done),
        .o_busy(busy), .o_sent(sent), .o_drop(drop), .o_error(error)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_err = 0;
    int          n_fstart = 0, n_sent = 0, n_drop = 0, n_txs = 0;
    logic [7:0]  txq[$];
    int          fpu_cnt = 0, tx_cnt = 0;
    int          fpu_lat = 5;
    bit          fpu_en = 1'b1;
    logic [31:0] fpu_val = '0;

    // Pulse monitor plus FPU / Tx serializer models.
    always @(negedge clk) begin
        if (fpu_start) n_fstart++;
        if (sent)      n_sent++;
        if (drop)      n_drop++;
        if (tx_start)  n_txs++;
        fpu_done = 1'b0;
        tx_done  = 1'b0;
        if (!rst_n) begin
            fpu_cnt   = 0;
            tx_cnt    = 0;
            tx_busy_m = 1'b0;
        end else begin
            if (fpu_start && fpu_en) begin
                fpu_cnt = fpu_lat;
            end else if (fpu_cnt > 0) begin
                fpu_cnt--;
                if (fpu_cnt == 0) begin
                    fpu_done = 1'b1;
                    fpu_res  = fpu_val;
                end
            end
            if (tx_start) begin
                txq.push_back(tx_data);
                tx_cnt    = TX_LEN;
                tx_busy_m = 1'b1;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_busy_m = 1'b0;
                    tx_done   = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        rx_done = 1'b1;
        da = a;
        db = b;
        step();
        rx_done = 1'b0;
    endtask

    task automatic wait_sent(input int base, input string nm);
        int k = 0;
        while (n_sent == base && k < 400) begin
            step();
            k++;
        end
        chk(nm, n_sent - base, 1);
    endtask

    task automatic chk_bytes(input int base, input logic [3:0][7:0] eb, input string nm);
        chk({nm, "_nbytes"}, txq.size() - base, 4);
        if (txq.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("%s_byte%0d", nm, k), txq[base+k], eb[3-k]);
            end
        end
    endtask

    // One complete transaction, checked end to end.
    task automatic run_vec(input vec_t v, input logic exp_err, input string nm);
        int fs0 = n_fstart;
        int s0  = n_sent;
        int d0  = n_drop;
        int b0  = txq.size();
        fpu_val = v.res;
        fpu_lat = v.lat;
        launch(v.a, v.b);
        chk({nm, "_busy_at_accept"}, busy, 1);
        chk({nm, "_no_start_yet"}, fpu_start, 0);
        step();
        chk({nm, "_fpu_start"}, fpu_start, 1);
        chk({nm, "_fpu_a"}, fpu_a, v.a);
        chk({nm, "_fpu_b"}, fpu_b, v.b);
        wait_sent(s0, {nm, "_sent"});
        chk_bytes(b0, v.eb, nm);
        chk({nm, "_one_launch"}, n_fstart - fs0, 1);
        chk({nm, "_busy_done"}, busy, 0);
        chk({nm, "_no_drop"}, n_drop - d0, 0);
        chk({nm, "_error"}, error, exp_err);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input int lat,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        vec_t v;
        v.a   = a;
        v.b   = b;
        v.res = res;
        v.lat = lat;
        v.eb  = {e0, e1, e2, e3};
        return v;
    endfunction

    vec_t vecs[5];

    initial begin
        int          fs0, d0, b0, t0, s0, k;
        logic        stable;
        vecs[0] = mk(32'h3F800000, 32'h40000000, 32'h40400000, 5,  8'h40, 8'h40, 8'h00, 8'h00);
        vecs[1] = mk(32'h12345678, 32'h9ABCDEF0, 32'hC0A00000, 1,  8'hC0, 8'hA0, 8'h00, 8'h00);
        vecs[2] = mk(32'hBF800000, 32'h3F800000, 32'hA1B2C3D4, 14, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        vecs[3] = mk(32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 3,  8'hFF, 8'hFF, 8'hFF, 8'hFF);
        // done lands on the cycle the watchdog reaches TO-1: must not error
        vecs[4] = mk(32'h7F7FFFFF, 32'h00800000, 32'h00000001, 15, 8'h00, 8'h00, 8'h00, 8'h01);

        // reset state
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_fpu_start", fpu_start, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_error", error, 0);
        rst_n = 1'b1;
        step();

        // table: vectors issued back-to-back right after each o_sent
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // second pair during WAIT_FPU is dropped
        fs0 = n_fstart; b0 = txq.size(); s0 = n_sent;
        fpu_val = 32'h11223344; fpu_lat = 10;
        launch(32'h3F800000, 32'h40000000);
        step(); step(); step();
        d0 = n_drop;
        launch(32'hDEADBEEF, 32'h0BADF00D);
        chk("drop_pulse", drop, 1);
        step();
        chk("drop_one_cycle", drop, 0);
        chk("drop_count", n_drop - d0, 1);
        chk("drop_keep_a", fpu_a, 32'h3F800000);
        chk("drop_keep_b", fpu_b, 32'h40000000);
        wait_sent(s0, "drop_sent");
        chk_bytes(b0, {8'h11, 8'h22, 8'h33, 8'h44}, "drop");
        chk("drop_one_launch", n_fstart - fs0, 1);

        // Tx busy held for 20 cycles on entry to SEND
        force_busy = 1'b1;
        b0 = txq.size(); s0 = n_sent;
        fpu_val = 32'hCAFEF00D; fpu_lat = 3;
        launch(32'h40A00000, 32'h40C00000);
        k = 0;
        while (!fpu_done && k < 50) begin step(); k++; end
        chk("hold_fpu_done_seen", fpu_done, 1);
        step();
        t0 = n_txs; stable = 1'b1;
        repeat (20) begin
            step();
            if (tx_data !== 8'h44) stable = 1'b0;
        end
        chk("hold_no_start", n_txs - t0, 0);
        chk("hold_data_stable", stable, 1);
        force_busy = 1'b0;
        step();
        chk("hold_start_after_release", n_txs - t0, 1);
        chk("hold_first_byte", tx_data, 8'hCA);
        wait_sent(s0, "hold_sent");
        chk_bytes(b0, {8'hCA, 8'hFE, 8'hF0, 8'h0D}, "hold");

        // watchdog: FPU never answers
        fpu_en = 1'b0;
        t0 = n_txs;
        launch(32'h1, 32'h2);
        step();
        chk("to_fpu_start", fpu_start, 1);
        k = 0;
        while (error !== 1'b1 && k <= 40) begin step(); k++; end
        chk("to_cycles", k, TO);
        chk("to_idle", busy, 0);
        chk("to_no_tx", n_txs - t0, 0);
        fpu_en = 1'b1;
        run_vec(vecs[0], 1'b1, "after_to");

        // async reset after the 2nd byte goes out
        b0 = txq.size();
        fpu_val = 32'h87654321; fpu_lat = 2;
        launch(32'h5, 32'h6);
        k = 0;
        while (txq.size() < b0 + 2 && k < 200) begin step(); k++; end
        chk("rst_mid_two_bytes", txq.size() - b0, 2);
        chk("rst_mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_error", error, 0);
        chk("rst_mid_tx_data", tx_data, 0);
        chk("rst_mid_fpu_a", fpu_a, 0);
        chk("rst_mid_fpu_b", fpu_b, 0);
        chk("rst_mid_pulses", {fpu_start, tx_start, sent, drop}, 0);
        step(); step();
        rst_n = 1'b1;
        s0 = n_sent; t0 = n_txs;
        repeat (30) step();
        chk("rst_post_no_sent", n_sent - s0, 0);
        chk("rst_post_no_tx", n_txs - t0, 0);
        chk("rst_post_idle", busy, 0);
        run_vec(vecs[2], 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
